// File: rtl/inst_rr_scheduler_if.sv
// Purpose: request/grant bundle between sibling instances and the round-robin scheduler.
// Latency: none, wires only.
// Backpressure: none; requests are levels, release is a single-cycle pulse from the owner.
// Ports: req (per-instance level request), release_pulse (owner finished),
//        gnt (one-hot grant), gnt_valid, gnt_id, timeout (hold-expiry pulse), grant_cnt.
interface inst_rr_scheduler_if #(
    parameter int NUM_REQ = 5
);
    logic [NUM_REQ-1:0] req;
    logic               release_pulse;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [2:0]         gnt_id;
    logic               timeout;
    logic [15:0]        grant_cnt;

    // Requester side.
    modport master (
        output req,
        output release_pulse,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  timeout,
        input  grant_cnt
    );

    // Scheduler side.
    modport slave (
        input  req,
        input  release_pulse,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output timeout,
        output grant_cnt
    );
endinterface

// File: rtl/inst_rr_scheduler.sv
// Purpose: round-robin owner selection for NUM_REQ sibling instances sharing one resource.
// Latency: req sampled at an edge in IDLE shows up as a registered gnt after that same edge.
// Backpressure: owner keeps gnt until release, req drop or MAX_HOLD expiry; one GAP cycle follows.
// Ports: clk, rst_n (async active-low), bus (slave side of inst_rr_scheduler_if).
module inst_rr_scheduler #(
    parameter int NUM_REQ  = 5,
    parameter int MAX_HOLD = 16
) (
    input logic                clk,
    input logic                rst_n,
    inst_rr_scheduler_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]         state;
    logic [2:0]         ptr;
    logic [7:0]         hold_cnt;
    logic [NUM_REQ-1:0] gnt_r;
    logic               gnt_valid_r;
    logic [2:0]         gnt_id_r;
    logic               timeout_r;
    logic [15:0]        grant_cnt_r;

    logic [7:0]         req_ext;
    logic [3:0]         cand;
    logic               win_found;
    logic [2:0]         win_idx;
    logic               owner_req;
    logic               hold_expired;
    logic               grant_exit;
    logic [2:0]         ptr_next;

    // Zero-padded to 8 so any 3-bit index is in range regardless of NUM_REQ.
    assign req_ext = 8'(bus.req);

    // First requester at or after ptr, wrapping at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!win_found && req_ext[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    assign owner_req    = req_ext[gnt_id_r];
    assign hold_expired = (hold_cnt == 8'(MAX_HOLD - 1));
    assign grant_exit   = bus.release_pulse | ~owner_req | hold_expired;
    assign ptr_next     = (gnt_id_r == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_id_r + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= 3'd0;
            hold_cnt    <= 8'd0;
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
            gnt_id_r    <= 3'd0;
            timeout_r   <= 1'b0;
            grant_cnt_r <= 16'd0;
        end else begin
            timeout_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state       <= ST_GRANT;
                        gnt_r       <= NUM_REQ'(1) << win_idx;
                        gnt_valid_r <= 1'b1;
                        gnt_id_r    <= win_idx;
                        hold_cnt    <= 8'd0;
                        grant_cnt_r <= grant_cnt_r + 16'd1;
                    end
                end
                ST_GRANT: begin
                    if (grant_exit) begin
                        state       <= ST_GAP;
                        gnt_r       <= '0;
                        gnt_valid_r <= 1'b0;
                        hold_cnt    <= 8'd0;
                        ptr         <= ptr_next;
                        // A release in the expiry cycle counts as a normal release.
                        timeout_r   <= hold_expired & ~bus.release_pulse;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.gnt_id    = gnt_id_r;
    assign bus.timeout   = timeout_r;
    assign bus.grant_cnt = grant_cnt_r;
endmodule

// File: tb/tb_inst_rr_scheduler.sv
// Purpose: self-checking bench for inst_rr_scheduler (NUM_REQ=5, MAX_HOLD=16).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bench plays all requesters through the master modport.
module tb_inst_rr_scheduler;
    localparam int NR       = 5;
    localparam int MAX_HOLD = 16;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    inst_rr_scheduler_if #(.NUM_REQ(NR)) bus ();

    inst_rr_scheduler #(.NUM_REQ(NR), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0] req;
        int         hold;
        int         exp_id;
        int         exp_wait;
    } vec_t;

    vec_t tbl [12];

    // Reference model: who owns the resource, how long it has held it,
    // whether the mandatory gap cycle is pending, and the rotation start.
    int          m_owner;
    int          m_held;
    int          m_gap;
    int          m_ptr;
    int          m_id;
    int          m_cnt;
    logic        m_timeout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            step();
            n++;
            if (bus.gnt_valid) break;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus.release_pulse = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_held    = 0;
        m_gap     = 0;
        m_ptr     = 0;
        m_id      = 0;
        m_cnt     = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] r, input logic rl);
        bit expired;
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            // The owner may keep gnt for at most MAX_HOLD cycles.
            expired = (m_held == MAX_HOLD);
            if (rl || !r[m_owner] || expired) begin
                m_timeout = expired && !rl;
                m_ptr     = (m_owner + 1) % NR;
                m_owner   = -1;
                m_gap     = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (m_owner < 0 && r[i]) begin
                    m_owner = i;
                    m_id    = i;
                    m_held  = 1;
                    m_cnt   = (m_cnt + 1) % 65536;
                end
            end
        end
    endtask

    initial begin
        int         n;
        int         held;
        logic [4:0] exp_gnt;
        logic [4:0] cur_req;
        logic       rl;
        bit         quiet;

        tbl[0]  = '{5'b11111, 0, 0, 1};
        tbl[1]  = '{5'b11111, 1, 1, 2};
        tbl[2]  = '{5'b11111, 2, 2, 2};
        tbl[3]  = '{5'b11111, 0, 3, 2};
        tbl[4]  = '{5'b11111, 3, 4, 2};
        tbl[5]  = '{5'b11111, 1, 0, 2};
        tbl[6]  = '{5'b10001, 0, 4, 2};
        tbl[7]  = '{5'b10001, 2, 0, 2};
        tbl[8]  = '{5'b00110, 1, 1, 2};
        tbl[9]  = '{5'b01001, 0, 3, 2};
        tbl[10] = '{5'b00011, 2, 0, 2};
        tbl[11] = '{5'b00100, 1, 2, 2};

        // Reset values, checked while reset is still asserted.
        rst_n = 1'b0;
        bus.req = '0;
        bus.release_pulse = 1'b0;
        step();
        step();
        chk("rst_gnt",       32'(bus.gnt),       32'd0);
        chk("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        chk("rst_gnt_id",    32'(bus.gnt_id),    32'd0);
        chk("rst_timeout",   32'(bus.timeout),   32'd0);
        chk("rst_grant_cnt", 32'(bus.grant_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_no_req_gnt", 32'(bus.gnt), 32'd0);

        // Table: full rotation, pointer wrap with sparse requests, gap length.
        for (int i = 0; i < 12; i++) begin
            bus.req = tbl[i].req;
            wait_grant(10, n);
            exp_gnt = 5'b00001 << tbl[i].exp_id;
            chk($sformatf("tbl%0d_wait", i),   32'(n),             32'(tbl[i].exp_wait));
            chk($sformatf("tbl%0d_gnt_id", i), 32'(bus.gnt_id),    32'(tbl[i].exp_id));
            chk($sformatf("tbl%0d_gnt", i),    32'(bus.gnt),       32'(exp_gnt));
            chk($sformatf("tbl%0d_cnt", i),    32'(bus.grant_cnt), 32'(i + 1));
            for (int h = 0; h < tbl[i].hold; h++) begin
                step();
                chk($sformatf("tbl%0d_hold_gnt", i), 32'(bus.gnt), 32'(exp_gnt));
            end
            bus.release_pulse = 1'b1;
            step();
            bus.release_pulse = 1'b0;
            chk($sformatf("tbl%0d_rel_valid", i),   32'(bus.gnt_valid), 32'd0);
            chk($sformatf("tbl%0d_rel_timeout", i), 32'(bus.timeout),   32'd0);
        end

        // Hold expiry with a single persistent requester.
        bus.req = 5'b00010;
        wait_grant(10, n);
        chk("exp_wait",   32'(n),          32'd2);
        chk("exp_gnt_id", 32'(bus.gnt_id), 32'd1);
        held = 1;
        while (held < 40) begin
            step();
            if (!bus.gnt_valid) break;
            held++;
        end
        chk("exp_hold_len", 32'(held),        32'(MAX_HOLD));
        chk("exp_timeout",  32'(bus.timeout), 32'd1);
        step();
        chk("exp_timeout_pulse", 32'(bus.timeout),   32'd0);
        chk("exp_gap_gnt",       32'(bus.gnt_valid), 32'd0);
        wait_grant(10, n);
        chk("exp_regrant_wait", 32'(n),             32'd1);
        chk("exp_regrant_id",   32'(bus.gnt_id),    32'd1);
        chk("exp_regrant_cnt",  32'(bus.grant_cnt), 32'd14);

        // Release arriving in the expiry cycle behaves as a release.
        for (int h = 0; h < MAX_HOLD - 1; h++) begin
            step();
        end
        chk("sim_still_valid", 32'(bus.gnt_valid), 32'd1);
        bus.release_pulse = 1'b1;
        step();
        bus.release_pulse = 1'b0;
        chk("sim_drop",    32'(bus.gnt_valid), 32'd0);
        chk("sim_timeout", 32'(bus.timeout),   32'd0);

        // Release while idle changes nothing.
        bus.req = '0;
        step();
        step();
        bus.release_pulse = 1'b1;
        step();
        bus.release_pulse = 1'b0;
        chk("idle_rel_valid",   32'(bus.gnt_valid), 32'd0);
        chk("idle_rel_timeout", 32'(bus.timeout),   32'd0);
        chk("idle_rel_cnt",     32'(bus.grant_cnt), 32'd14);
        bus.req = 5'b00001;
        wait_grant(10, n);
        chk("idle_rel_wait", 32'(n),          32'd1);
        chk("idle_rel_id",   32'(bus.gnt_id), 32'd0);

        // Reset in the middle of a grant to instance 3.
        bus.release_pulse = 1'b1;
        step();
        bus.release_pulse = 1'b0;
        bus.req = 5'b01000;
        wait_grant(10, n);
        chk("mid_rst_pre_id", 32'(bus.gnt_id), 32'd3);
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",     32'(bus.gnt),       32'd0);
        chk("mid_rst_valid",   32'(bus.gnt_valid), 32'd0);
        chk("mid_rst_cnt",     32'(bus.grant_cnt), 32'd0);
        chk("mid_rst_timeout", 32'(bus.timeout),   32'd0);
        chk("mid_rst_id",      32'(bus.gnt_id),    32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(bus.gnt_valid), 32'd1);
        chk("post_rst_id",    32'(bus.gnt_id),    32'd3);
        chk("post_rst_cnt",   32'(bus.grant_cnt), 32'd1);

        // Single requester from reset, released three cycles into the grant.
        do_reset();
        bus.req = 5'b00100;
        step();
        chk("single_gnt",    32'(bus.gnt),       32'h04);
        chk("single_id",     32'(bus.gnt_id),    32'd2);
        chk("single_cnt",    32'(bus.grant_cnt), 32'd1);
        step();
        step();
        bus.release_pulse = 1'b1;
        step();
        bus.release_pulse = 1'b0;
        chk("single_drop",    32'(bus.gnt),       32'd0);
        chk("single_timeout", 32'(bus.timeout),   32'd0);
        chk("single_cnt_end", 32'(bus.grant_cnt), 32'd1);

        // Random traffic against the reference model; alternating phases
        // with and without releases so that hold expiry is also exercised.
        do_reset();
        model_reset();
        cur_req = '0;
        for (int c = 0; c < 3000; c++) begin
            quiet = ((c / 250) % 2) == 1;
            if ($urandom_range(0, quiet ? 40 : 7) == 0) begin
                cur_req = 5'($urandom_range(0, 31));
            end
            rl = quiet ? 1'b0 : ($urandom_range(0, 9) == 0);
            bus.req = cur_req;
            bus.release_pulse = rl;
            step();
            model_step(cur_req, rl);
            exp_gnt = (m_owner >= 0) ? (5'b00001 << m_owner) : 5'b00000;
            chk("rnd_gnt",       32'(bus.gnt),       32'(exp_gnt));
            chk("rnd_gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
            chk("rnd_gnt_id",    32'(bus.gnt_id),    32'(m_id));
            chk("rnd_timeout",   32'(bus.timeout),   32'(m_timeout));
            chk("rnd_grant_cnt", 32'(bus.grant_cnt), 32'(m_cnt));
        end
        bus.release_pulse = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
